// File: rtl/victory_ctrl_if.sv
// Game-outcome bus between the move logic, victory_ctrl and the victory-screen renderer.
// The master side drives the game events; the slave side (victory_ctrl) returns the outcome.
interface victory_ctrl_if;
    logic       new_game;
    logic       cap_by_p1;
    logic       cap_by_p2;
    logic       resign_p1;
    logic       resign_p2;
    logic       Player_1_v;
    logic       Player_2_v;
    logic       game_active;
    logic [3:0] p1_count;
    logic [3:0] p2_count;

    modport master (
        output new_game, cap_by_p1, cap_by_p2, resign_p1, resign_p2,
        input  Player_1_v, Player_2_v, game_active, p1_count, p2_count
    );

    modport slave (
        input  new_game, cap_by_p1, cap_by_p2, resign_p1, resign_p2,
        output Player_1_v, Player_2_v, game_active, p1_count, p2_count
    );
endinterface

// File: rtl/victory_ctrl.sv
// Checkers outcome controller: tracks pawn counts, detects the winner and drives
// the one-hot victory-screen selects after a suspense delay.
//
// state   | meaning
// IDLE    | after reset, waiting for the first new_game
// PLAY    | game running, captures/resigns accepted
// DECLARE | winner latched, suspense timer counting down
// SHOW    | winner select asserted until new_game
module victory_ctrl #(
    parameter int PAWNS        = 12,
    parameter int DELAY_CYCLES = 50_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    victory_ctrl_if.slave io_game
);

    localparam int             TW      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [TW-1:0]  T_LOAD  = TW'(DELAY_CYCLES - 1);
    localparam logic [3:0]     P_START = 4'(PAWNS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DECLARE,
        S_SHOW
    } state_t;

    state_t        r_state;
    logic [3:0]    r_p1_cnt;
    logic [3:0]    r_p2_cnt;
    logic [TW-1:0] r_timer;
    logic          r_win_p2;
    logic          r_p1_v;
    logic          r_p2_v;
    logic          r_active;

    state_t        w_state_nxt;
    logic [3:0]    w_p1_nxt;
    logic [3:0]    w_p2_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_win_p2_nxt;
    logic [3:0]    w_p1_dec;
    logic [3:0]    w_p2_dec;

    // Saturating decrements; the win check below looks at these next-count values.
    assign w_p2_dec = (io_game.cap_by_p1 && (r_p2_cnt != 4'd0)) ? r_p2_cnt - 4'd1 : r_p2_cnt;
    assign w_p1_dec = (io_game.cap_by_p2 && (r_p1_cnt != 4'd0)) ? r_p1_cnt - 4'd1 : r_p1_cnt;

    always_comb begin
        w_state_nxt  = r_state;
        w_p1_nxt     = r_p1_cnt;
        w_p2_nxt     = r_p2_cnt;
        w_timer_nxt  = r_timer;
        w_win_p2_nxt = r_win_p2;

        if (io_game.new_game) begin
            w_state_nxt  = S_PLAY;
            w_p1_nxt     = P_START;
            w_p2_nxt     = P_START;
            w_timer_nxt  = '0;
            w_win_p2_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_PLAY: begin
                    w_p1_nxt = w_p1_dec;
                    w_p2_nxt = w_p2_dec;
                    // P1 has fixed priority on a double empty or double resign
                    if ((w_p2_dec == 4'd0) || io_game.resign_p2) begin
                        w_state_nxt  = S_DECLARE;
                        w_win_p2_nxt = 1'b0;
                        w_timer_nxt  = T_LOAD;
                    end else if ((w_p1_dec == 4'd0) || io_game.resign_p1) begin
                        w_state_nxt  = S_DECLARE;
                        w_win_p2_nxt = 1'b1;
                        w_timer_nxt  = T_LOAD;
                    end
                end
                S_DECLARE: begin
                    if (r_timer == '0) begin
                        w_state_nxt = S_SHOW;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                S_SHOW: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_p1_cnt <= P_START;
            r_p2_cnt <= P_START;
            r_timer  <= '0;
            r_win_p2 <= 1'b0;
            r_p1_v   <= 1'b0;
            r_p2_v   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_p1_cnt <= w_p1_nxt;
            r_p2_cnt <= w_p2_nxt;
            r_timer  <= w_timer_nxt;
            r_win_p2 <= w_win_p2_nxt;
            r_p1_v   <= (w_state_nxt == S_SHOW) && !w_win_p2_nxt;
            r_p2_v   <= (w_state_nxt == S_SHOW) &&  w_win_p2_nxt;
            r_active <= (w_state_nxt == S_PLAY);
        end
    end

    assign io_game.Player_1_v  = r_p1_v;
    assign io_game.Player_2_v  = r_p2_v;
    assign io_game.game_active = r_active;
    assign io_game.p1_count    = r_p1_cnt;
    assign io_game.p2_count    = r_p2_cnt;

endmodule

// File: tb/tb_victory_ctrl.sv
// Bench for victory_ctrl: directed game scenarios plus random play, all checked
// every cycle against an event-level game model.
module tb_victory_ctrl;

    localparam int PAWNS = 12;
    localparam int DELAY = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    victory_ctrl_if game_if ();

    victory_ctrl #(.PAWNS(PAWNS), .DELAY_CYCLES(DELAY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_game (game_if.slave)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;

    // Game model: phase 0 = idle, 1 = playing, 2 = awaiting reveal, 3 = screen shown
    int m_phase;
    int m_p1;
    int m_p2;
    int m_winner;
    int m_show_cyc;

    task automatic check_val(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_p1       = PAWNS;
        m_p2       = PAWNS;
        m_winner   = 0;
        m_show_cyc = 0;
    endtask

    task automatic model_edge(input bit ng, input bit c1, input bit c2, input bit r1, input bit r2);
        cyc++;
        if (ng) begin
            m_phase  = 1;
            m_p1     = PAWNS;
            m_p2     = PAWNS;
            m_winner = 0;
        end else if (m_phase == 1) begin
            if (c1 && m_p2 > 0) m_p2--;
            if (c2 && m_p1 > 0) m_p1--;
            if (m_p2 == 0 || r2) m_winner = 1;
            else if (m_p1 == 0 || r1) m_winner = 2;
            if (m_winner != 0) begin
                m_phase    = 2;
                m_show_cyc = cyc + DELAY;
            end
        end else if (m_phase == 2 && cyc >= m_show_cyc) begin
            m_phase = 3;
        end
    endtask

    task automatic check_all();
        check_val("p1_count",    int'(game_if.p1_count),    m_p1);
        check_val("p2_count",    int'(game_if.p2_count),    m_p2);
        check_val("game_active", int'(game_if.game_active), (m_phase == 1) ? 1 : 0);
        check_val("Player_1_v",  int'(game_if.Player_1_v),  (m_phase == 3 && m_winner == 1) ? 1 : 0);
        check_val("Player_2_v",  int'(game_if.Player_2_v),  (m_phase == 3 && m_winner == 2) ? 1 : 0);
        check_val("onehot_inv",  int'(game_if.Player_1_v & game_if.Player_2_v), 0);
    endtask

    task automatic step(input bit ng, input bit c1, input bit c2, input bit r1, input bit r2);
        @(negedge clk);
        game_if.new_game  = ng;
        game_if.cap_by_p1 = c1;
        game_if.cap_by_p2 = c2;
        game_if.resign_p1 = r1;
        game_if.resign_p2 = r2;
        @(posedge clk);
        model_edge(ng, c1, c2, r1, r2);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        game_if.new_game  = 1'b0;
        game_if.cap_by_p1 = 1'b0;
        game_if.cap_by_p2 = 1'b0;
        game_if.resign_p1 = 1'b0;
        game_if.resign_p2 = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Inputs other than new_game are ignored in IDLE
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // P1 wipes out P2 one pawn at a time
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PAWNS; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(DELAY + 2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Double capture down to 1/1 then simultaneous empty: P1 wins
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PAWNS - 1; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(DELAY + 1);

        // Resign by P1 at 7/9; later captures must not move the score
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PAWNS - 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < PAWNS - 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DELAY + 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Abort on the second DECLARE cycle, then new_game from SHOW
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(DELAY + 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(DELAY + 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // DELAY+1 idle edges after the resign guarantees SHOW before the async reset
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(DELAY + 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Random play
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(99) < 3),
                 ($urandom_range(99) < 35),
                 ($urandom_range(99) < 35),
                 ($urandom_range(199) < 2),
                 ($urandom_range(199) < 2));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
